// File: rtl/seq_det_pkg.sv
// Shared encodings for the sequence detector and its hit-rate monitor.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_t;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_THRESH  = 3;

  // 101 detector states; the monitor itself never uses them
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_S1   = 2'd1,
    DS_S10  = 2'd2
  } det_state_t;

endpackage

// File: rtl/seq_win_timer.sv
// Window cycle counter; win_last marks the final cycle of each WIN_LEN window.
module seq_win_timer #(
  parameter int WIN_LEN = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic win_last
);

  localparam int W = $clog2(WIN_LEN);
  localparam logic [W-1:0] LAST = W'(WIN_LEN - 1);

  logic [W-1:0] win_cnt;

  // Held at zero while not running so every run starts at window cycle 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             win_cnt <= '0;
    else if (!run)           win_cnt <= '0;
    else if (win_cnt == LAST) win_cnt <= '0;
    else                     win_cnt <= win_cnt + 1'b1;
  end

  assign win_last = run && (win_cnt == LAST);

endmodule

// File: rtl/seq_hit_rate_monitor.sv
// Counts detector hits per WIN_LEN-cycle window and publishes a valid/ready report.
module seq_hit_rate_monitor
  import seq_det_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int THRESH  = DEF_THRESH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             hit,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_alarm,
  output logic             ovf,
  output logic             busy
);

  // A threshold above the counter range can never be reached
  localparam longint MAXV     = (64'd1 << CNT_W) - 64'd1;
  localparam bit     ALARM_EN = longint'(THRESH) <= MAXV;
  localparam logic [CNT_W-1:0] THR_C = ALARM_EN ? CNT_W'(THRESH) : '0;

  mon_state_t state, state_nxt;
  logic             run, win_last, load;
  logic [CNT_W-1:0] hit_cnt, hit_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropping en discards the partial window on the same edge
  assign run  = (state == RUN) && en;
  assign busy = (state == RUN);

  seq_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .win_last (win_last)
  );

  assign hit_sum = (&hit_cnt) ? hit_cnt : hit_cnt + CNT_W'(hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       hit_cnt <= '0;
    else if (!run)     hit_cnt <= '0;
    else if (win_last) hit_cnt <= '0;
    else               hit_cnt <= hit_sum;
  end

  // A window end may reload the report on the very edge it is accepted
  assign load = win_last && (!rpt_valid || rpt_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_alarm <= 1'b0;
    end else if (load) begin
      rpt_valid <= 1'b1;
      rpt_count <= hit_sum;
      rpt_alarm <= ALARM_EN && (hit_sum >= THR_C);
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   ovf <= 1'b0;
    else if (state == IDLE && en)                  ovf <= 1'b0;
    else if (win_last && rpt_valid && !rpt_ready)  ovf <= 1'b1;
  end

endmodule
